// File: rtl/uart_alici_tampon_pkg.sv
// Shared constants for the UART receive FIFO slice.
package uart_alici_tampon_pkg;

   localparam logic HIGH = 1'b1;
   localparam logic LOW  = 1'b0;

endpackage

// File: rtl/fifo_bellek.sv
// Register-array storage for the receive FIFO: one synchronous write port,
// one asynchronous read port, contents are not reset.
module fifo_bellek #(
   parameter int DERINLIK       = 16,
   parameter int VERI_GENISLIGI = 8
) (
   input  logic                        clk_i,
   input  logic                        yaz_en_i,
   input  logic [$clog2(DERINLIK)-1:0] yaz_adr_i,
   input  logic [VERI_GENISLIGI-1:0]   yaz_veri_i,
   input  logic [$clog2(DERINLIK)-1:0] oku_adr_i,
   output logic [VERI_GENISLIGI-1:0]   oku_veri_o
);

   logic [VERI_GENISLIGI-1:0] mem [DERINLIK];

   always_ff @(posedge clk_i) begin
      if (yaz_en_i) mem[yaz_adr_i] <= yaz_veri_i;
   end

   assign oku_veri_o = mem[oku_adr_i];

endmodule

// File: rtl/uart_alici_tampon.sv
// First-word-fall-through receive FIFO behind the UART receiver.
// Optional threshold outputs are built when UART_ALICI_TAMPON_ESIK_EN is defined.
module uart_alici_tampon
   import uart_alici_tampon_pkg::*;
#(
   parameter int DERINLIK       = 16,
   parameter int VERI_GENISLIGI = 8
`ifdef UART_ALICI_TAMPON_ESIK_EN
   ,parameter int ESIK          = 8
`endif
) (
   input  logic                      clk_i,
   input  logic                      rst_i,
   input  logic [VERI_GENISLIGI-1:0] alinan_veri_i,
   input  logic                      alinan_gecerli_i,
   output logic [VERI_GENISLIGI-1:0] veri_o,
   output logic                      gecerli_o,
   input  logic                      hazir_i,
   output logic                      bos_o,
   output logic                      dolu_o,
   output logic                      tasma_o,
   input  logic                      tasma_temizle_i,
   input  logic                      bosalt_i
`ifdef UART_ALICI_TAMPON_ESIK_EN
   ,output logic [$clog2(DERINLIK):0] doluluk_o,
   output logic                      esik_o
`endif
);

   localparam int AW = $clog2(DERINLIK);
   localparam int CW = AW + 1;

   logic [AW-1:0]             yaz_ptr, oku_ptr;
   logic [CW-1:0]             sayac;
   logic                      tasma_q;
   logic [VERI_GENISLIGI-1:0] oku_veri;
   logic                      push, pop, dusur;

   assign bos_o     = (sayac == '0);
   assign dolu_o    = (sayac == CW'(DERINLIK));
   assign gecerli_o = !bos_o;
   assign tasma_o   = tasma_q;
   assign veri_o    = bos_o ? '0 : oku_veri;

   // A full FIFO still accepts a byte when the head leaves in the same cycle.
   assign pop   = gecerli_o && hazir_i;
   assign push  = alinan_gecerli_i && (!dolu_o || pop);
   assign dusur = alinan_gecerli_i && dolu_o && !pop && !bosalt_i;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         yaz_ptr <= '0;
         oku_ptr <= '0;
         sayac   <= '0;
      end else if (bosalt_i) begin
         yaz_ptr <= '0;
         oku_ptr <= '0;
         sayac   <= '0;
      end else begin
         if (push) yaz_ptr <= yaz_ptr + AW'(1);
         if (pop)  oku_ptr <= oku_ptr + AW'(1);
         if (push && !pop)      sayac <= sayac + CW'(1);
         else if (pop && !push) sayac <= sayac - CW'(1);
      end
   end

   // Set beats clear when a drop and a clear request coincide.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i)                tasma_q <= LOW;
      else if (dusur)           tasma_q <= HIGH;
      else if (tasma_temizle_i) tasma_q <= LOW;
   end

   fifo_bellek #(
      .DERINLIK       (DERINLIK),
      .VERI_GENISLIGI (VERI_GENISLIGI)
   ) u_bellek (
      .clk_i      (clk_i),
      .yaz_en_i   (push && !bosalt_i),
      .yaz_adr_i  (yaz_ptr),
      .yaz_veri_i (alinan_veri_i),
      .oku_adr_i  (oku_ptr),
      .oku_veri_o (oku_veri)
   );

`ifdef UART_ALICI_TAMPON_ESIK_EN
   assign doluluk_o = sayac;
   assign esik_o    = (sayac >= CW'(ESIK));
`endif

endmodule

// File: tb/tb_uart_alici_tampon.sv
// Randomized scoreboard bench for uart_alici_tampon against a queue-based model.
module tb_uart_alici_tampon;

   localparam int DER = 16;
   localparam int VG  = 8;

   logic          clk_i = 1'b0;
   logic          rst_i = 1'b1;
   logic [VG-1:0] alinan_veri_i = '0;
   logic          alinan_gecerli_i = 1'b0;
   logic [VG-1:0] veri_o;
   logic          gecerli_o;
   logic          hazir_i = 1'b0;
   logic          bos_o, dolu_o, tasma_o;
   logic          tasma_temizle_i = 1'b0;
   logic          bosalt_i = 1'b0;
`ifdef UART_ALICI_TAMPON_ESIK_EN
   logic [4:0]    doluluk_o;
   logic          esik_o;
`endif

   uart_alici_tampon #(.DERINLIK(DER), .VERI_GENISLIGI(VG)) dut (
      .clk_i            (clk_i),
      .rst_i            (rst_i),
      .alinan_veri_i    (alinan_veri_i),
      .alinan_gecerli_i (alinan_gecerli_i),
      .veri_o           (veri_o),
      .gecerli_o        (gecerli_o),
      .hazir_i          (hazir_i),
      .bos_o            (bos_o),
      .dolu_o           (dolu_o),
      .tasma_o          (tasma_o),
      .tasma_temizle_i  (tasma_temizle_i),
      .bosalt_i         (bosalt_i)
`ifdef UART_ALICI_TAMPON_ESIK_EN
      ,.doluluk_o       (doluluk_o),
      .esik_o           (esik_o)
`endif
   );

   always #5 clk_i = ~clk_i;

   int n_vec = 0;
   int n_err = 0;

   logic [VG-1:0] model_q[$];
   logic [VG-1:0] exp_q[$];
   bit            model_tasma = 1'b0;

   task automatic check(string nm, logic [31:0] act, logic [31:0] req);
      n_vec++;
      if (act !== req) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, req, $time);
      end
   endtask

   // Reference model: a plain queue of stored bytes, updated on each clock.
   always @(posedge clk_i or posedge rst_i) begin : model
      int  n;
      bit  m_pop, m_acc, m_drop;
      if (rst_i) begin
         model_q.delete();
         exp_q.delete();
         model_tasma = 1'b0;
      end else begin
         n      = model_q.size();
         m_pop  = (n > 0) && hazir_i;
         m_acc  = alinan_gecerli_i && (n < DER || m_pop);
         m_drop = alinan_gecerli_i && !m_acc && !bosalt_i;
         if (bosalt_i) begin
            model_q.delete();
            exp_q.delete();
         end else begin
            if (m_pop) void'(model_q.pop_front());
            if (m_acc) begin
               model_q.push_back(alinan_veri_i);
               exp_q.push_back(alinan_veri_i);
            end
         end
         if (m_drop) model_tasma = 1'b1;
         else if (tasma_temizle_i) model_tasma = 1'b0;
      end
   end

   // Monitor: compare outputs mid-cycle; consume expected bytes on handshakes.
   always @(negedge clk_i) begin
      check("bos_o", {31'd0, bos_o}, {31'd0, model_q.size() == 0});
      check("dolu_o", {31'd0, dolu_o}, {31'd0, model_q.size() == DER});
      check("gecerli_o", {31'd0, gecerli_o}, {31'd0, model_q.size() != 0});
      check("tasma_o", {31'd0, tasma_o}, {31'd0, model_tasma});
`ifdef UART_ALICI_TAMPON_ESIK_EN
      check("doluluk_o", {27'd0, doluluk_o}, model_q.size());
      check("esik_o", {31'd0, esik_o}, {31'd0, model_q.size() >= 8});
`endif
      if (gecerli_o) begin
         if (exp_q.size() == 0) check("veri_beklenmeyen", {31'd0, gecerli_o}, 32'd0);
         else begin
            check("veri_o", {24'd0, veri_o}, {24'd0, exp_q[0]});
            if (hazir_i) void'(exp_q.pop_front());
         end
      end else begin
         check("veri_o_bos", {24'd0, veri_o}, 32'd0);
      end
   end

   task automatic step(bit v, logic [VG-1:0] d, bit h, bit tz = 1'b0, bit bs = 1'b0);
      alinan_gecerli_i = v;
      alinan_veri_i    = d;
      hazir_i          = h;
      tasma_temizle_i  = tz;
      bosalt_i         = bs;
      @(posedge clk_i);
      #1;
   endtask

   task automatic drain();
      int k = 0;
      while (!bos_o && k < 40) begin
         step(1'b0, '0, 1'b1);
         k++;
      end
      check("drain_bos", {31'd0, bos_o}, 32'd1);
   endtask

   task automatic fill(int cnt, logic [VG-1:0] base);
      for (int i = 0; i < cnt; i++) step(1'b1, base + VG'(i), 1'b0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int pushed, guard;
      bit v, h;
      repeat (3) @(posedge clk_i);
      #1 rst_i = 1'b0;
      check("reset_bos", {31'd0, bos_o}, 32'd1);
      check("reset_veri", {24'd0, veri_o}, 32'd0);

      // single byte fall-through
      step(1'b1, 8'hA5, 1'b0);
      check("t1_gecerli", {31'd0, gecerli_o}, 32'd1);
      check("t1_veri", {24'd0, veri_o}, 32'hA5);
      step(1'b0, '0, 1'b1);
      check("t1_bos", {31'd0, bos_o}, 32'd1);
      check("t1_veri0", {24'd0, veri_o}, 32'd0);

      // fill, overflow drop, drain in order
      fill(16, 8'h00);
      check("t2_dolu", {31'd0, dolu_o}, 32'd1);
      step(1'b1, 8'h10, 1'b0);
      check("t2_tasma", {31'd0, tasma_o}, 32'd1);
      check("t2_bas", {24'd0, veri_o}, 32'h00);
      drain();
      step(1'b0, '0, 1'b0, 1'b1);
      check("t2_temizle", {31'd0, tasma_o}, 32'd0);

      // push and pop together while full
      fill(16, 8'h20);
      step(1'b1, 8'h55, 1'b1);
      check("t3_dolu", {31'd0, dolu_o}, 32'd1);
      check("t3_tasma", {31'd0, tasma_o}, 32'd0);
      check("t3_bas", {24'd0, veri_o}, 32'h21);
      drain();

      // randomized traffic across pointer wrap
      pushed = 0;
      guard  = 0;
      while (pushed < 40 && guard < 400) begin
         v = 1'($urandom_range(0, 1));
         h = 1'($urandom_range(0, 1));
         if (dolu_o && !h) v = 1'b0;
         step(v, VG'($urandom), h);
         if (v) pushed++;
         guard++;
      end
      check("t4_pushed", pushed, 32'd40);
      drain();

      // drop and clear in the same cycle
      fill(16, 8'h40);
      step(1'b1, 8'h77, 1'b0, 1'b1);
      check("t5_set_wins", {31'd0, tasma_o}, 32'd1);
      step(1'b0, '0, 1'b0, 1'b1);
      check("t5_temizle", {31'd0, tasma_o}, 32'd0);
      drain();

      // flush with coincident push, then async reset mid-drain
      fill(5, 8'h60);
      step(1'b1, 8'h99, 1'b0, 1'b0, 1'b1);
      check("t6_bosalt", {31'd0, bos_o}, 32'd1);
      fill(5, 8'h70);
      step(1'b0, '0, 1'b1);
      #3 rst_i = 1'b1;
      #1;
      check("t6_rst_gecerli", {31'd0, gecerli_o}, 32'd0);
      check("t6_rst_bos", {31'd0, bos_o}, 32'd1);
      @(posedge clk_i);
      #1 rst_i = 1'b0;
      step(1'b0, '0, 1'b0);

`ifdef UART_ALICI_TAMPON_ESIK_EN
      fill(7, 8'h80);
      check("t6_esik7", {31'd0, esik_o}, 32'd0);
      step(1'b1, 8'h87, 1'b0);
      check("t6_esik8", {31'd0, esik_o}, 32'd1);
      check("t6_doluluk8", {27'd0, doluluk_o}, 32'd8);
      drain();
`endif

      step(1'b0, '0, 1'b0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
